// File: rtl/rv32i_types.sv
// Shared RV32I memory-interface types: port words, lane masks, responder FSM state
// and the captured request payload.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_BUSY = 2'd1,
    MR_RESP = 2'd2
  } mem_resp_state_t;

  // Latency counter width: holds LATENCY-1 (max 14) plus up to 3 stall cycles
  localparam int unsigned MR_CNT_W = 5;

  // Request fields latched when the responder accepts a transaction
  typedef struct packed {
    logic           is_write;
    logic           in_range;
    rv32i_word      wdata;
    rv32i_mem_wmask be;
  } mem_req_t;

  // Merge write data into an old word, one byte lane per mask bit
  function automatic rv32i_word merge_lanes(input rv32i_word old_word,
                                            input rv32i_word wdata,
                                            input rv32i_mem_wmask be);
    rv32i_word result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying random stall cycles.
// Present only when MEM_RAND_STALL_EN is defined.
`ifdef MEM_RAND_STALL_EN
module mem_stall_lfsr (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  localparam logic [15:0] SEED = 16'hACE1;

  logic feedback;

  // Feedback from taps 16,14,13,11 (bit indices 15,13,12,10)
  always_comb begin
    feedback = value[15] ^ value[13] ^ value[12] ^ value[10];
  end

  // Free-running shift register, reseeded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= {value[14:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised backing RAM answering the CPU data-memory
// handshake after a fixed latency, with a sticky protocol/range error flag.
// Optional MEM_RAND_STALL_EN adds 0-3 random stall cycles per transaction.
module data_mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_word      mem_address,
  input  rv32i_word      mem_wdata,
  input  rv32i_mem_wmask mem_byte_enable,
  output rv32i_word      mem_rdata,
  output logic           mem_resp,
  output logic           proto_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  rv32i_word ram [DEPTH];

  mem_resp_state_t       state_q, state_d;
  logic [MR_CNT_W-1:0]   cnt_q, cnt_d, load;
  mem_req_t              req_q, req_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  resp_d, err_d, ram_we, addr_in_range;
  rv32i_word             rdata_d;
  logic [1:0]            stall;

`ifdef MEM_RAND_STALL_EN
  logic [15:0] lfsr_value;
  logic        unused_lfsr_bits;

  mem_stall_lfsr u_stall_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign stall            = lfsr_value[1:0];
  assign unused_lfsr_bits = ^lfsr_value[15:2];
`else
  assign stall = 2'b00;
`endif

  // Any set bit above the word index puts the address outside the RAM
  assign addr_in_range = (mem_address >> (ADDR_WIDTH + 2)) == 32'd0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, capture and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    err_d   = proto_err;
    resp_d  = 1'b0;
    rdata_d = '0;
    ram_we  = 1'b0;
    load    = MR_CNT_W'(LATENCY - 1) + MR_CNT_W'(stall);

    unique case (state_q)
      MR_IDLE: begin
        if (mem_read || mem_write) begin
          req_d.is_write = mem_write;
          req_d.in_range = addr_in_range;
          req_d.wdata    = mem_wdata;
          req_d.be       = mem_byte_enable;
          idx_d          = mem_address[ADDR_WIDTH+1:2];
          cnt_d          = load;
          if ((mem_read && mem_write) || !addr_in_range) begin
            err_d = 1'b1;
          end
          state_d = (load == '0) ? MR_RESP : MR_BUSY;
        end
      end
      MR_BUSY: begin
        if (!mem_read && !mem_write) begin
          state_d = MR_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= MR_CNT_W'(1)) begin
          state_d = MR_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - MR_CNT_W'(1);
        end
      end
      MR_RESP: begin
        state_d = MR_IDLE;
        ram_we  = req_q.is_write && req_q.in_range;
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase

    // Response registers are loaded on the edge entering MR_RESP
    if (state_d == MR_RESP) begin
      resp_d  = 1'b1;
      rdata_d = (!req_d.is_write && req_d.in_range) ? ram[idx_d] : '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      idx_q     <= idx_d;
      mem_resp  <= resp_d;
      mem_rdata <= rdata_d;
      proto_err <= err_d;
    end
  end

  // Lane-masked RAM write at the close of the response cycle; reset cancels it
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram[idx_q] <= merge_lanes(ram[idx_q], req_q.wdata, req_q.be);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver queues expected responses,
// a negedge monitor pops and compares them whenever mem_resp is high.
module tb_data_mem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 3;
`ifdef MEM_RAND_STALL_EN
  localparam int STALL_MAX = 3;
`else
  localparam int STALL_MAX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    bit          chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  data_mem_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LATENCY    (LATENCY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pops one expectation; idle cycles must show zero data
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_resp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc < e.cyc || cyc > e.cyc + STALL_MAX) begin
          errors++;
          $display("FAIL resp_latency got cycle %0d expected %0d..%0d", cyc, e.cyc, e.cyc + STALL_MAX);
        end
        if (e.chk_data) begin
          checks++;
          if (mem_rdata !== e.data) begin
            errors++;
            $display("FAIL rdata got %h expected %h", mem_rdata, e.data);
          end
        end
        checks++;
        if (proto_err !== e.err) begin
          errors++;
          $display("FAIL resp_proto_err got %b expected %b", proto_err, e.err);
        end
      end
    end else begin
      checks++;
      if (mem_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata got %h expected 00000000 at cycle %0d", mem_rdata, cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_resp && n < 40);
    checks++;
    if (!mem_resp) begin
      errors++;
      $display("FAIL %s_timeout got no resp expected resp within 40 cycles", name);
    end
  endtask

  // One transaction; optional scramble changes the request inputs while busy
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input bit chk,
                     input logic [31:0] exp_data, input logic exp_err, input bit scramble);
    int n = 0;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    exp_q.push_back('{cyc + LATENCY, chk, exp_data, exp_err});
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble && !mem_resp) begin
        mem_address     = addr ^ 32'h0000_000C;
        mem_wdata       = ~wd;
        mem_byte_enable = ~be;
      end
    end while (!mem_resp && n < 40);
    checks++;
    if (!mem_resp) begin
      errors++;
      $display("FAIL txn_timeout addr %h got no resp expected resp", addr);
    end
    idle_cycle();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                    input logic exp_err);
    txn(1'b0, 1'b1, addr, wd, be, 1'b0, 32'h0, exp_err, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    txn(1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b1, exp_data, exp_err, 1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    check("reset_resp", 32'(mem_resp), 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_proto_err", 32'(proto_err), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check(name, 32'(mem_resp), 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Full write then read, lane-masked overwrite, and an empty mask
    wr(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(32'h100, 32'hDEADBEEF, 1'b0);
    wr(32'h100, 32'h11223344, 4'b0101, 1'b0);
    rd(32'h100, 32'hDE22BE44, 1'b0);
    wr(32'h100, 32'hFFFFFFFF, 4'b0000, 1'b0);
    rd(32'h100, 32'hDE22BE44, 1'b0);

    // Inputs changed while busy must not affect the captured write
    txn(1'b0, 1'b1, 32'h104, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
    rd(32'h104, 32'h12345678, 1'b0);

    // Abort after one busy cycle: no response, no write
    wr(32'h200, 32'hCAFEF00D, 4'hF, 1'b0);
    mem_write = 1'b1; mem_address = 32'h200; mem_wdata = 32'h0; mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_write = 1'b0;
    expect_quiet("abort_no_resp", 6);
    rd(32'h200, 32'hCAFEF00D, 1'b0);

    // Simultaneous read and write acts as a write and flags an error
    wr(32'h40, 32'hA5A5A5A5, 4'hF, 1'b0);
    txn(1'b1, 1'b1, 32'h20, 32'h00000077, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    rd(32'h20, 32'h00000077, 1'b1);

    // Reset during the busy phase of a write cancels it and clears outputs
    mem_write = 1'b1; mem_address = 32'h40; mem_wdata = 32'h0; mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_resp", 32'(mem_resp), 32'h0);
    check("rst_mid_rdata", mem_rdata, 32'h0);
    check("rst_mid_proto_err", 32'(proto_err), 32'h0);
    rst = 1'b0;
    expect_quiet("rst_mid_no_resp", 5);
    rd(32'h40, 32'hA5A5A5A5, 1'b0);

    // Out-of-range accesses: zero data, dropped write, sticky error
    wr(32'h0, 32'h13579BDF, 4'hF, 1'b0);
    rd(32'h0001_0000, 32'h0, 1'b1);
    wr(32'h0000_1000, 32'hFFFFFFFF, 4'hF, 1'b1);
    rd(32'h0, 32'h13579BDF, 1'b1);
    wr(32'h10, 32'h0BADCAFE, 4'hF, 1'b1);
    rd(32'h10, 32'h0BADCAFE, 1'b1);
    check("sticky_proto_err", 32'(proto_err), 32'h1);

    // Back-to-back reads with mem_read held across the first response
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h100;
    exp_q.push_back('{cyc + LATENCY, 1'b1, 32'hDE22BE44, 1'b1});
    wait_resp("b2b_first");
    mem_address = 32'h104;
    exp_q.push_back('{cyc + 1 + LATENCY, 1'b1, 32'h12345678, 1'b1});
    wait_resp("b2b_second");
    idle_cycle();

    do_reset();
    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
